// File: rtl/regfile_wb_bypass_if.sv
// WB-stage write port and ID-stage read ports of the LEGv8 register file.
// The ID/WB pipeline side is the master; the register file is the slave.
interface regfile_wb_bypass_if #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_wb_bypass.sv
// 32 x 64-bit LEGv8 register file with two combinational read ports,
// a decoder-tree write port, optional WB->ID write-through and XZR tied to zero.
module regfile_wb_bypass #(
    parameter int WIDTH  = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_wb_bypass_if.slave    rf
);

    localparam logic [ADDR_W-1:0] XZR_ADDR = ADDR_W'(NREGS - 1);

    // One 1-to-2 enable decoder: {enable for sel=1, enable for sel=0}.
    function automatic logic [1:0] dec1to2(input logic en, input logic sel);
        return {en & sel, en & ~sel};
    endfunction

    // Read-port mux priority: reset, then XZR, then write-through, then storage.
    function automatic logic [WIDTH-1:0] rd_sel(
        input logic              rst_act,
        input logic [ADDR_W-1:0] ra,
        input logic              byp_hit,
        input logic [WIDTH-1:0]  wdata,
        input logic [WIDTH-1:0]  stored
    );
        logic [WIDTH-1:0] res;
        if (rst_act) begin
            res = {WIDTH{1'b0}};
        end else if (ra == XZR_ADDR) begin
            res = {WIDTH{1'b0}};
        end else if (byp_hit) begin
            res = wdata;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    logic [2*NREGS-1:0] dec_tree_s;
    logic [NREGS-1:0]   wr_en_s;
    logic [WIDTH-1:0]   regs_r [NREGS];
    logic               byp1_s;
    logic               byp2_s;

    // Heap-ordered decoder tree: node n splits into 2n/2n+1 on one address bit, MSB first,
    // so leaf NREGS+k is the enable for register k.
    always_comb begin
        dec_tree_s    = '0;
        dec_tree_s[1] = rf.RegWrite;
        for (int l = 0; l < ADDR_W; l++) begin
            for (int j = 0; j < (1 << l); j++) begin
                dec_tree_s[2*((1 << l) + j) +: 2] =
                    dec1to2(dec_tree_s[(1 << l) + j], rf.WriteRegister[ADDR_W-1-l]);
            end
        end
    end

    assign wr_en_s = dec_tree_s[2*NREGS-1:NREGS];

    // Register storage; the XZR slot is cleared by reset and never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < NREGS - 1; k++) begin
                if (wr_en_s[k]) begin
                    regs_r[k] <= rf.WriteData;
                end else begin
                    regs_r[k] <= regs_r[k];
                end
            end
        end
    end

    // Same-cycle write-through hit detection for each read port.
    always_comb begin
        byp1_s = 1'b0;
        byp2_s = 1'b0;
        if (BYPASS != 0) begin
            byp1_s = rf.RegWrite && (rf.ReadRegister1 == rf.WriteRegister);
            byp2_s = rf.RegWrite && (rf.ReadRegister2 == rf.WriteRegister);
        end else begin
            byp1_s = 1'b0;
            byp2_s = 1'b0;
        end
    end

    // Combinational read ports.
    always_comb begin
        rf.ReadData1 = rd_sel(!reset_n, rf.ReadRegister1, byp1_s, rf.WriteData,
                              regs_r[rf.ReadRegister1]);
        rf.ReadData2 = rd_sel(!reset_n, rf.ReadRegister2, byp2_s, rf.WriteData,
                              regs_r[rf.ReadRegister2]);
    end

endmodule

// File: tb/tb_regfile_wb_bypass.sv
// Randomized bench for regfile_wb_bypass: a BYPASS=1 and a BYPASS=0 instance share stimulus
// and are checked every cycle against an array model, plus directed literal checks.
module tb_regfile_wb_bypass;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_bypass_if #(.WIDTH(64), .ADDR_W(5)) bus1 ();
    regfile_wb_bypass_if #(.WIDTH(64), .ADDR_W(5)) bus0 ();

    assign bus0.RegWrite      = bus1.RegWrite;
    assign bus0.WriteRegister = bus1.WriteRegister;
    assign bus0.WriteData     = bus1.WriteData;
    assign bus0.ReadRegister1 = bus1.ReadRegister1;
    assign bus0.ReadRegister2 = bus1.ReadRegister2;

    regfile_wb_bypass #(.WIDTH(64), .NREGS(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
        .clk(clk), .reset_n(reset_n), .rf(bus1)
    );
    regfile_wb_bypass #(.WIDTH(64), .NREGS(32), .ADDR_W(5), .BYPASS(0)) dut_nobyp (
        .clk(clk), .reset_n(reset_n), .rf(bus0)
    );

    // Architectural state model.
    logic [63:0] mdl [32];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 32; k++) mdl[k] <= 64'd0;
        end else if (bus1.RegWrite && bus1.WriteRegister != 5'd31) begin
            mdl[bus1.WriteRegister] <= bus1.WriteData;
        end
    end

    function automatic logic [63:0] exp_rd(input logic [4:0] ra, input bit byp);
        if (!reset_n) return 64'd0;
        if (ra == 5'd31) return 64'd0;
        if (byp && bus1.RegWrite && ra == bus1.WriteRegister) return bus1.WriteData;
        return mdl[ra];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drv(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        bus1.RegWrite      = we;
        bus1.WriteRegister = wa;
        bus1.WriteData     = wd;
        bus1.ReadRegister1 = r1;
        bus1.ReadRegister2 = r2;
    endtask

    // Every-cycle comparison of all four read ports against the model.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (cmp_en) begin
                chk("byp_rd1",   bus1.ReadData1, exp_rd(bus1.ReadRegister1, 1'b1));
                chk("byp_rd2",   bus1.ReadData2, exp_rd(bus1.ReadRegister2, 1'b1));
                chk("nobyp_rd1", bus0.ReadData1, exp_rd(bus1.ReadRegister1, 1'b0));
                chk("nobyp_rd2", bus0.ReadData2, exp_rd(bus1.ReadRegister2, 1'b0));
            end
        end
    end

    localparam logic [63:0] C5 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C6 = 64'hDEADBEEF00000001;

    initial begin
        reset_n            = 1'b0;
        bus1.RegWrite      = 1'b0;
        bus1.WriteRegister = 5'd0;
        bus1.WriteData     = 64'd0;
        bus1.ReadRegister1 = 5'd0;
        bus1.ReadRegister2 = 5'd0;
        cmp_en             = 1'b1;
        #1;
        chk("por_rd1", bus1.ReadData1, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Preload every register with all ones, then async reset mid-cycle.
        for (int a = 0; a < 32; a++) drv(1'b1, 5'(a), 64'hFFFF_FFFF_FFFF_FFFF, 5'(a), 5'd15);
        drv(1'b0, 5'd0, 64'd0, 5'd30, 5'd15);
        #4 chk("preload_x30", bus1.ReadData1, 64'hFFFF_FFFF_FFFF_FFFF);
        drv(1'b0, 5'd0, 64'd0, 5'd0, 5'd15);
        #2 reset_n = 1'b0;
        #1 chk("rst_x0", bus1.ReadData1, 64'd0);
        chk("rst_x15", bus1.ReadData2, 64'd0);
        bus1.ReadRegister1 = 5'd30;
        #1 chk("rst_x30", bus1.ReadData1, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Write/readback.
        drv(1'b1, 5'd5, C5, 5'd0, 5'd0);
        drv(1'b1, 5'd6, C6, 5'd0, 5'd0);
        drv(1'b0, 5'd0, 64'd0, 5'd5, 5'd6);
        #4 chk("wr_x5", bus1.ReadData1, C5);
        chk("wr_x6", bus0.ReadData2, C6);
        drv(1'b0, 5'd0, 64'd0, 5'd4, 5'd7);
        #4 chk("x4_zero", bus1.ReadData1, 64'd0);
        chk("x7_zero", bus1.ReadData2, 64'd0);

        // RegWrite gating.
        drv(1'b0, 5'd9, 64'h55, 5'd9, 5'd9);
        #4 chk("gate_x9_off", bus1.ReadData1, 64'd0);
        drv(1'b1, 5'd9, 64'h55, 5'd9, 5'd9);
        #4 chk("gate_byp", bus1.ReadData1, 64'h55);
        chk("gate_nobyp", bus0.ReadData1, 64'd0);
        drv(1'b0, 5'd0, 64'd0, 5'd9, 5'd9);
        #4 chk("gate_x9_on", bus0.ReadData2, 64'h55);

        // XZR.
        drv(1'b1, 5'd31, 64'hAAAA, 5'd31, 5'd5);
        #4 chk("xzr_pre", bus1.ReadData1, 64'd0);
        drv(1'b0, 5'd0, 64'd0, 5'd31, 5'd5);
        #4 chk("xzr_post", bus1.ReadData1, 64'd0);
        chk("xzr_x5", bus1.ReadData2, C5);

        // Bypass on both ports.
        drv(1'b1, 5'd3, 64'h10, 5'd0, 5'd0);
        drv(1'b1, 5'd3, 64'h20, 5'd3, 5'd3);
        #4 chk("byp_p1", bus1.ReadData1, 64'h20);
        chk("byp_p2", bus1.ReadData2, 64'h20);
        chk("nobyp_p1", bus0.ReadData1, 64'h10);
        chk("nobyp_p2", bus0.ReadData2, 64'h10);
        drv(1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
        #4 chk("byp_after", bus0.ReadData1, 64'h20);

        // Reset during a write.
        drv(1'b1, 5'd12, 64'h77, 5'd12, 5'd12);
        #2 reset_n = 1'b0;
        #1 chk("rst_no_byp", bus1.ReadData1, 64'd0);
        @(negedge clk);
        bus1.RegWrite = 1'b0;
        reset_n       = 1'b1;
        #4 chk("rst_lost_x12", bus1.ReadData1, 64'd0);
        drv(1'b1, 5'd12, 64'h77, 5'd0, 5'd0);
        drv(1'b0, 5'd0, 64'd0, 5'd12, 5'd0);
        #4 chk("rewrite_x12", bus1.ReadData1, 64'h77);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 800; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drv($urandom_range(0, 3) != 0, wa, {$urandom, $urandom},
                ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 99) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
